// File: rtl/sram_arb_pkg.sv
// Shared definitions for the dual-port SRAM arbiter: default widths and
// the requester identifier encoding used by the arbiters and the read pipe.
package sram_arb_pkg;

  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_WMASKS_DEF = 4;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // The requester that gets priority after the given one has been served.
  function automatic req_id_e other_id(input req_id_e id);
    req_id_e res;
    case (id)
      REQ_A:   res = REQ_B;
      REQ_B:   res = REQ_A;
      default: res = REQ_A;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The tentative winner (cand) depends only on
// the requests and the priority pointer, so the parent can inspect it and
// veto the grant through block; a vetoed cycle leaves the pointer alone.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    req_a,
  input  logic    req_b,
  input  logic    block,
  output req_id_e cand,
  output logic    cand_valid,
  output logic    gnt_a,
  output logic    gnt_b
);

  req_id_e prio_r;

  // Pick the tentative winner and qualify it into grants.
  always_comb begin
    cand       = REQ_A;
    cand_valid = req_a | req_b;
    if (req_a && req_b) begin
      cand = prio_r;
    end else if (req_b) begin
      cand = REQ_B;
    end else begin
      cand = REQ_A;
    end
    gnt_a = cand_valid & ~block & (cand == REQ_A);
    gnt_b = cand_valid & ~block & (cand == REQ_B);
  end

  // Priority pointer: hand priority to the other requester after each grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_r <= REQ_A;
    end else if (gnt_a) begin
      prio_r <= other_id(REQ_A);
    end else if (gnt_b) begin
      prio_r <= other_id(REQ_B);
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbiter in front of a 1W/1R SRAM macro. Writes and reads are arbitrated
// independently; a read colliding with a same-cycle real write to the same
// address is held off one cycle. Read data returns two cycles after grant.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_WMASKS = NUM_WMASKS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  csb0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);

  logic wr_req_a_s, wr_req_b_s, rd_req_a_s, rd_req_b_s;
  logic wr_gnt_a_s, wr_gnt_b_s, rd_gnt_a_s, rd_gnt_b_s;
  logic wr_cand_valid_s, rd_cand_valid_s;
  req_id_e wr_cand_s, rd_cand_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s, rd_addr_s;
  logic [NUM_WMASKS-1:0] wr_mask_s;
  logic hazard_s;

  logic    rd_v1_r;
  req_id_e rd_tag1_r;

  // Split requests per SRAM port; nothing is requested while in reset.
  always_comb begin
    wr_req_a_s = a_req & a_we & ~rst;
    wr_req_b_s = b_req & b_we & ~rst;
    rd_req_a_s = a_req & ~a_we & ~rst;
    rd_req_b_s = b_req & ~b_we & ~rst;
  end

  rr_arb2 u_wr_arb (
    .clk        (clk),
    .rst        (rst),
    .req_a      (wr_req_a_s),
    .req_b      (wr_req_b_s),
    .block      (1'b0),
    .cand       (wr_cand_s),
    .cand_valid (wr_cand_valid_s),
    .gnt_a      (wr_gnt_a_s),
    .gnt_b      (wr_gnt_b_s)
  );

  rr_arb2 u_rd_arb (
    .clk        (clk),
    .rst        (rst),
    .req_a      (rd_req_a_s),
    .req_b      (rd_req_b_s),
    .block      (hazard_s),
    .cand       (rd_cand_s),
    .cand_valid (rd_cand_valid_s),
    .gnt_a      (rd_gnt_a_s),
    .gnt_b      (rd_gnt_b_s)
  );

  // Same-address hazard between the write winner and the tentative read winner.
  always_comb begin
    wr_addr_s = a_addr;
    wr_mask_s = a_wmask;
    rd_addr_s = a_addr;
    if (wr_cand_s == REQ_B) begin
      wr_addr_s = b_addr;
      wr_mask_s = b_wmask;
    end else begin
      wr_addr_s = a_addr;
      wr_mask_s = a_wmask;
    end
    if (rd_cand_s == REQ_B) begin
      rd_addr_s = b_addr;
    end else begin
      rd_addr_s = a_addr;
    end
    hazard_s = wr_cand_valid_s & rd_cand_valid_s & (|wr_mask_s) &
               (wr_addr_s == rd_addr_s);
  end

  // Requester grants: each requester uses exactly one port per cycle.
  always_comb begin
    a_gnt = wr_gnt_a_s | rd_gnt_a_s;
    b_gnt = wr_gnt_b_s | rd_gnt_b_s;
  end

  // Write port drive; an all-zero mask is granted but never selects the macro.
  always_comb begin
    csb0   = 1'b1;
    addr0  = '0;
    din0   = '0;
    wmask0 = '0;
    if (wr_gnt_a_s) begin
      csb0   = ~(|a_wmask);
      addr0  = a_addr;
      din0   = a_wdata;
      wmask0 = a_wmask;
    end else if (wr_gnt_b_s) begin
      csb0   = ~(|b_wmask);
      addr0  = b_addr;
      din0   = b_wdata;
      wmask0 = b_wmask;
    end else begin
      csb0   = 1'b1;
      addr0  = '0;
      din0   = '0;
      wmask0 = '0;
    end
  end

  // Read port drive.
  always_comb begin
    csb1  = 1'b1;
    addr1 = '0;
    if (rd_gnt_a_s) begin
      csb1  = 1'b0;
      addr1 = a_addr;
    end else if (rd_gnt_b_s) begin
      csb1  = 1'b0;
      addr1 = b_addr;
    end else begin
      csb1  = 1'b1;
      addr1 = '0;
    end
  end

  // First return stage: remember that a read was issued and who owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v1_r   <= 1'b0;
      rd_tag1_r <= REQ_A;
    end else begin
      rd_v1_r   <= rd_gnt_a_s | rd_gnt_b_s;
      rd_tag1_r <= rd_gnt_b_s ? REQ_B : REQ_A;
    end
  end

  // Second return stage: one-cycle valid pulse for the owning requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= rd_v1_r & (rd_tag1_r == REQ_A);
      b_rvalid <= rd_v1_r & (rd_tag1_r == REQ_B);
    end
  end

  // Capture macro output for the owner only; data holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (rd_v1_r && (rd_tag1_r == REQ_A)) begin
      a_rdata <= dout1;
      b_rdata <= b_rdata;
    end else if (rd_v1_r && (rd_tag1_r == REQ_B)) begin
      a_rdata <= a_rdata;
      b_rdata <= dout1;
    end else begin
      a_rdata <= a_rdata;
      b_rdata <= b_rdata;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: per-cycle vector table for grants and SRAM port
// drive, a behavioural 1W/1R macro, and a scoreboard for read returns.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [10:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic [3:0]  a_wmask, b_wmask;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        csb0, csb1;
  logic [3:0]  wmask0;
  logic [10:0] addr0, addr1;
  logic [31:0] din0, dout1;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_wmask(a_wmask),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wmask(b_wmask),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .csb1(csb1), .addr1(addr1), .dout1(dout1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM macro: registered read, byte-masked write.
  logic [31:0] sram_mem [0:2047];
  always @(posedge clk) begin
    if (!csb0) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask0[i]) sram_mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
      end
    end
    if (!csb1) dout1 <= sram_mem[addr1];
  end

  logic [31:0] ref_mem [0:2047];

  typedef struct {
    string       name;
    logic        a_req, a_we;
    logic [10:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_wmask;
    logic        b_req, b_we;
    logic [10:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_wmask;
    logic        e_a_gnt, e_b_gnt, e_csb0, e_csb1;
    logic [10:0] e_addr0;
    logic [31:0] e_din0;
    logic [3:0]  e_wmask0;
    logic [10:0] e_addr1;
  } vec_t;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  vec_t    vecs[$];
  rd_exp_t sb[$];
  int n_vec = 0;
  int n_mis = 0;
  logic [31:0] last_a = 32'h0;
  logic [31:0] last_b = 32'h0;

  function automatic vec_t mkv(string nm,
      logic ar, logic aw, logic [10:0] aa, logic [31:0] ad, logic [3:0] am,
      logic br, logic bw, logic [10:0] ba, logic [31:0] bd, logic [3:0] bm,
      logic ga, logic gb, logic c0, logic c1,
      logic [10:0] a0, logic [31:0] d0, logic [3:0] m0, logic [10:0] a1);
    vec_t v;
    v.name = nm;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad; v.a_wmask = am;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd; v.b_wmask = bm;
    v.e_a_gnt = ga; v.e_b_gnt = gb; v.e_csb0 = c0; v.e_csb1 = c1;
    v.e_addr0 = a0; v.e_din0 = d0; v.e_wmask0 = m0; v.e_addr1 = a1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input vec_t v);
    a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata; a_wmask = v.a_wmask;
    b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata; b_wmask = v.b_wmask;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_a_gnt"}, {31'd0, a_gnt}, 32'd0);
    chk({nm, "_b_gnt"}, {31'd0, b_gnt}, 32'd0);
    chk({nm, "_csb0"}, {31'd0, csb0}, 32'd1);
    chk({nm, "_csb1"}, {31'd0, csb1}, 32'd1);
    chk({nm, "_addr0"}, {21'd0, addr0}, 32'd0);
    chk({nm, "_addr1"}, {21'd0, addr1}, 32'd0);
    chk({nm, "_din0"}, din0, 32'd0);
    chk({nm, "_wmask0"}, {28'd0, wmask0}, 32'd0);
    chk({nm, "_a_rvalid"}, {31'd0, a_rvalid}, 32'd0);
    chk({nm, "_b_rvalid"}, {31'd0, b_rvalid}, 32'd0);
    chk({nm, "_a_rdata"}, a_rdata, 32'd0);
    chk({nm, "_b_rdata"}, b_rdata, 32'd0);
  endtask

  // Read-return scoreboard: order, owner, data and exact latency.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      n_vec++;
      n_mis++;
      $display("FAIL rvalid_missing: got none expected owner %0d data %h", sb[0].owner, sb[0].data);
      void'(sb.pop_front());
    end
    if (a_rvalid || b_rvalid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL rvalid_unexpected: got a=%0d b=%0d expected none (cycle %0d)", a_rvalid, b_rvalid, cyc);
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        chk("rv_owner_a", {31'd0, a_rvalid}, {31'd0, ~e.owner});
        chk("rv_owner_b", {31'd0, b_rvalid}, {31'd0, e.owner});
        chk("rv_data", e.owner ? b_rdata : a_rdata, e.data);
        chk("rv_latency", cyc, e.due);
        if (e.owner) last_b = e.data;
        else last_a = e.data;
      end
    end
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      sram_mem[i] = 32'hC0DE_0000 | i;
      ref_mem[i]  = 32'hC0DE_0000 | i;
    end

    //          name          a: req we addr    wdata         mask   b: req we addr    wdata         mask   ga gb c0 c1 addr0   din0          m0     addr1
    vecs.push_back(mkv("idle0",      0,0,11'h000,32'h0,        4'h0,  0,0,11'h000,32'h0,        4'h0,  0,0,1,1,11'h000,32'h0,        4'h0,  11'h000));
    vecs.push_back(mkv("rr_rd0",     1,0,11'h001,32'h0,        4'h0,  1,0,11'h002,32'h0,        4'h0,  1,0,1,0,11'h000,32'h0,        4'h0,  11'h001));
    vecs.push_back(mkv("rr_rd1",     1,0,11'h001,32'h0,        4'h0,  1,0,11'h002,32'h0,        4'h0,  0,1,1,0,11'h000,32'h0,        4'h0,  11'h002));
    vecs.push_back(mkv("rr_rd2",     1,0,11'h001,32'h0,        4'h0,  1,0,11'h002,32'h0,        4'h0,  1,0,1,0,11'h000,32'h0,        4'h0,  11'h001));
    vecs.push_back(mkv("rr_rd3",     1,0,11'h001,32'h0,        4'h0,  1,0,11'h002,32'h0,        4'h0,  0,1,1,0,11'h000,32'h0,        4'h0,  11'h002));
    vecs.push_back(mkv("wr_dead",    1,1,11'h010,32'hDEADBEEF, 4'hF,  0,0,11'h000,32'h0,        4'h0,  1,0,0,1,11'h010,32'hDEADBEEF, 4'hF,  11'h000));
    vecs.push_back(mkv("rd_dead",    1,0,11'h010,32'h0,        4'h0,  0,0,11'h000,32'h0,        4'h0,  1,0,1,0,11'h000,32'h0,        4'h0,  11'h010));
    vecs.push_back(mkv("haz_wr_rd",  1,1,11'h020,32'h12345678, 4'hF,  1,0,11'h020,32'h0,        4'h0,  1,0,0,1,11'h020,32'h12345678, 4'hF,  11'h000));
    vecs.push_back(mkv("rd_post_hz", 0,0,11'h000,32'h0,        4'h0,  1,0,11'h020,32'h0,        4'h0,  0,1,1,0,11'h000,32'h0,        4'h0,  11'h020));
    vecs.push_back(mkv("wr_ones",    0,0,11'h000,32'h0,        4'h0,  1,1,11'h030,32'hFFFFFFFF, 4'hF,  0,1,0,1,11'h030,32'hFFFFFFFF, 4'hF,  11'h000));
    vecs.push_back(mkv("wr_mask3",   0,0,11'h000,32'h0,        4'h0,  1,1,11'h030,32'hAAAA5555, 4'h3,  0,1,0,1,11'h030,32'hAAAA5555, 4'h3,  11'h000));
    vecs.push_back(mkv("wr_mask0",   1,1,11'h030,32'h01234567, 4'h0,  0,0,11'h000,32'h0,        4'h0,  1,0,1,1,11'h030,32'h01234567, 4'h0,  11'h000));
    vecs.push_back(mkv("rd_mask",    1,0,11'h030,32'h0,        4'h0,  0,0,11'h000,32'h0,        4'h0,  1,0,1,0,11'h000,32'h0,        4'h0,  11'h030));
    vecs.push_back(mkv("wr_cont",    1,1,11'h040,32'h11111111, 4'hF,  1,1,11'h041,32'h22222222, 4'hF,  0,1,0,1,11'h041,32'h22222222, 4'hF,  11'h000));
    vecs.push_back(mkv("wr_a_next",  1,1,11'h040,32'h11111111, 4'hF,  0,0,11'h000,32'h0,        4'h0,  1,0,0,1,11'h040,32'h11111111, 4'hF,  11'h000));
    vecs.push_back(mkv("wr_rd_par",  1,1,11'h050,32'h00000055, 4'hF,  1,0,11'h040,32'h0,        4'h0,  1,1,0,0,11'h050,32'h00000055, 4'hF,  11'h040));
    vecs.push_back(mkv("haz_mask0",  1,1,11'h060,32'h00000066, 4'h0,  1,0,11'h060,32'h0,        4'h0,  1,1,1,0,11'h060,32'h00000066, 4'h0,  11'h060));
    vecs.push_back(mkv("rd_cont",    1,0,11'h041,32'h0,        4'h0,  1,0,11'h050,32'h0,        4'h0,  1,0,1,0,11'h000,32'h0,        4'h0,  11'h041));
    vecs.push_back(mkv("b_wr_only",  0,0,11'h000,32'h0,        4'h0,  1,1,11'h070,32'h00000077, 4'hF,  0,1,0,1,11'h070,32'h00000077, 4'hF,  11'h000));
    vecs.push_back(mkv("idle1",      0,0,11'h000,32'h0,        4'h0,  0,0,11'h000,32'h0,        4'h0,  0,0,1,1,11'h000,32'h0,        4'h0,  11'h000));
    vecs.push_back(mkv("idle2",      0,0,11'h000,32'h0,        4'h0,  0,0,11'h000,32'h0,        4'h0,  0,0,1,1,11'h000,32'h0,        4'h0,  11'h000));
    vecs.push_back(mkv("idle3",      0,0,11'h000,32'h0,        4'h0,  0,0,11'h000,32'h0,        4'h0,  0,0,1,1,11'h000,32'h0,        4'h0,  11'h000));

    // Reset with requests active: everything must sit at reset values.
    rst = 1'b1;
    drive(mkv("init", 1,1,11'h005,32'h5555AAAA,4'hF, 1,0,11'h006,32'h0,4'h0, 0,0,1,1,11'h0,32'h0,4'h0,11'h0));
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset("rst_init");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive(v);
      @(negedge clk);
      chk({v.name, "_a_gnt"}, {31'd0, a_gnt}, {31'd0, v.e_a_gnt});
      chk({v.name, "_b_gnt"}, {31'd0, b_gnt}, {31'd0, v.e_b_gnt});
      chk({v.name, "_csb0"}, {31'd0, csb0}, {31'd0, v.e_csb0});
      chk({v.name, "_csb1"}, {31'd0, csb1}, {31'd0, v.e_csb1});
      chk({v.name, "_addr0"}, {21'd0, addr0}, {21'd0, v.e_addr0});
      chk({v.name, "_din0"}, din0, v.e_din0);
      chk({v.name, "_wmask0"}, {28'd0, wmask0}, {28'd0, v.e_wmask0});
      chk({v.name, "_addr1"}, {21'd0, addr1}, {21'd0, v.e_addr1});
      if (v.e_a_gnt && !v.a_we) sb.push_back('{1'b0, ref_mem[v.a_addr], cyc + 2});
      if (v.e_b_gnt && !v.b_we) sb.push_back('{1'b1, ref_mem[v.b_addr], cyc + 2});
      for (int k = 0; k < 4; k++) begin
        if (v.e_a_gnt && v.a_we && v.a_wmask[k]) ref_mem[v.a_addr][k*8 +: 8] = v.a_wdata[k*8 +: 8];
        if (v.e_b_gnt && v.b_we && v.b_wmask[k]) ref_mem[v.b_addr][k*8 +: 8] = v.b_wdata[k*8 +: 8];
      end
      @(posedge clk);
      #1;
    end

    // Read data must hold while rvalid is low.
    @(negedge clk);
    chk("hold_a_rdata", a_rdata, last_a);
    chk("hold_b_rdata", b_rdata, last_b);
    @(posedge clk);
    #1;

    // Read granted, then reset for one cycle: the return must be flushed.
    drive(mkv("rd_pre_rst", 1,0,11'h010,32'h0,4'h0, 0,0,11'h0,32'h0,4'h0, 0,0,1,1,11'h0,32'h0,4'h0,11'h0));
    @(negedge clk);
    chk("pre_rst_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("pre_rst_csb1", {31'd0, csb1}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(mkv("in_rst", 1,1,11'h011,32'h13572468,4'hF, 1,0,11'h012,32'h0,4'h0, 0,0,1,1,11'h0,32'h0,4'h0,11'h0));
    @(negedge clk);
    check_reset("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First cycle after reset: grant is immediate and priority favours a.
    drive(mkv("post_rst", 1,0,11'h001,32'h0,4'h0, 1,0,11'h002,32'h0,4'h0, 0,0,1,1,11'h0,32'h0,4'h0,11'h0));
    @(negedge clk);
    chk("post_rst_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("post_rst_b_gnt", {31'd0, b_gnt}, 32'd0);
    sb.push_back('{1'b0, ref_mem[11'h001], cyc + 2});
    @(posedge clk);
    #1;
    drive(mkv("post_rst_b", 0,0,11'h000,32'h0,4'h0, 1,0,11'h002,32'h0,4'h0, 0,0,1,1,11'h0,32'h0,4'h0,11'h0));
    @(negedge clk);
    chk("post_rst_b_gnt2", {31'd0, b_gnt}, 32'd1);
    sb.push_back('{1'b1, ref_mem[11'h002], cyc + 2});
    @(posedge clk);
    #1;
    drive(mkv("drain", 0,0,11'h000,32'h0,4'h0, 0,0,11'h000,32'h0,4'h0, 0,0,1,1,11'h0,32'h0,4'h0,11'h0));
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter NUM_WMASKS, default 4, byte-enable width (DATA_WIDTH/8).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  single clock, shared with both SRAM port clocks.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 Requester port set for x in {a,b}: x_req  in  1  request, held until granted.
REQ-007 x_we  in  1  1 = write, 0 = read.
REQ-008 x_addr  in  ADDR_WIDTH  word address.
REQ-009 x_wdata  in  DATA_WIDTH  write data.
REQ-010 x_wmask  in  NUM_WMASKS  byte write enables.
REQ-011 x_gnt  out  1  request accepted this cycle.
REQ-012 x_rvalid  out  1  read data valid, one-cycle pulse.
REQ-013 x_rdata  out  DATA_WIDTH  read data.
REQ-014 SRAM write side: csb0 out 1 (active low); wmask0 out NUM_WMASKS; addr0 out ADDR_WIDTH; din0 out DATA_WIDTH.
REQ-015 SRAM read side: csb1 out 1 (active low); addr1 out ADDR_WIDTH; dout1 in DATA_WIDTH.

Function
REQ-016 Write and read ports SHALL be arbitrated independently; one write and one read MAY be granted in the same cycle.
REQ-017 Grant SHALL be combinational: x_gnt high in the same cycle as x_req when x wins its port; requester drops or changes request after the gnt cycle.
REQ-018 Each port SHALL use 2-way round-robin: on contention, the requester not most recently granted on that port wins; the pointer updates only on a grant.
REQ-019 Write grant cycle: csb0=0, addr0/din0/wmask0 = winner's fields; no write grant: csb0=1, other write outputs 0.
REQ-020 Write with x_wmask==0 SHALL be granted, with csb0 held at 1.
REQ-021 Read grant in cycle N: csb1=0, addr1=winner's x_addr; no read grant: csb1=1, addr1=0.
REQ-022 Read data SHALL be captured from dout1 at the clk edge ending cycle N+1; x_rvalid=1 and x_rdata valid in cycle N+2 for the granted requester only.
REQ-023 Back-to-back reads SHALL pipeline: a read may be granted every cycle, returning in order; the owner tag travels a 2-stage pipe.
REQ-024 x_rdata SHALL hold its last value when x_rvalid=0.
REQ-025 Hazard: when a read and a nonzero-mask write to the same address would be granted in the same cycle, the read grant SHALL be withheld that cycle (write proceeds), with the read pointer unchanged.
REQ-026 A single requester issuing a write SHALL never receive a read grant in that cycle, since x_we selects exactly one port.

Reset
REQ-027 While rst=1: all x_gnt=0, csb0=csb1=1, addr/din/wmask outputs 0, x_rvalid=0, x_rdata=0, both round-robin pointers favour a.
REQ-028 Reset asserted mid-read SHALL flush the return pipe; no x_rvalid for reads granted before or during reset.
REQ-029 The first grant SHALL occur in the first cycle after rst deasserts.

Structure
REQ-030 Shared package sram_arb_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH/NUM_WMASKS defaults and the requester ID encoding (REQ_A=0, REQ_B=1).
REQ-031 SHALL instantiate sub-module rr_arb2 (two-way round-robin with pointer) twice, once per SRAM port; the hazard check and read-return pipe stay in sram_arbiter.

Verification
REQ-032 a write addr 0x010 data 0xDEADBEEF mask 0xF, then a read 0x010 -> a_rvalid two cycles after the read grant, a_rdata=0xDEADBEEF.
REQ-033 a and b both read for 4 cycles (0x001/0x002) -> grants alternate a,b,a,b starting with a after reset; rvalid order matches.
REQ-034 Same cycle: a write 0x020=0x12345678 mask 0xF, b read 0x020 -> a_gnt=1, b_gnt=0; b granted next cycle and returns 0x12345678.
REQ-035 Write mask 0x3 data 0xAAAA5555 over 0xFFFFFFFF -> readback 0xFFFF5555; write with mask 0x0 -> gnt=1, csb0=1, memory unchanged.
REQ-036 Read granted, rst asserted the next cycle for 1 cycle -> no rvalid; all outputs at reset values while rst=1.
